// File: rtl/l3_miss_handler.sv
// L3 miss handler: looks up each upstream request in L3, fetches missing lines
// from RAM word by word, installs them through the fill port, and writes through.
module l3_miss_handler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_SIZE  = 16,
  localparam int LINE_W    = LINE_SIZE * 8,
  localparam int WORDS     = LINE_W / DATA_WIDTH,
  localparam int CNT_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int OFF_W     = $clog2(LINE_SIZE),
  localparam int WB_W      = $clog2(DATA_WIDTH / 8)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_w_data,
  output logic                  resp_valid,
  output logic [LINE_W-1:0]     resp_line,
  output logic                  l3_valid,
  output logic                  l3_we,
  output logic [ADDR_WIDTH-1:0] l3_addr,
  output logic [DATA_WIDTH-1:0] l3_w_data,
  input  logic [LINE_W-1:0]     l3_r_data,
  input  logic                  l3_hit,
  output logic                  fill_en,
  output logic                  fill_mark_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [LINE_W-1:0]     fill_data,
  output logic                  ram_re,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  input  logic                  ram_r_valid,
  output logic [2:0]            dbg_state
);

  // Handshake: a request transfers on a cycle where req_valid && req_ready;
  // req_ready is high only in IDLE, so the requester holds req_valid until then.
  typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, WAIT, FILL, WRITE, RESP} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt;
  logic [LINE_W-1:0]     buffer;
  logic [LINE_W-1:0]     resp_line_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [ADDR_WIDTH-1:0] fetch_addr;

  assign line_base  = {addr_q[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign word_addr  = {addr_q[ADDR_WIDTH-1:WB_W], WB_W'(0)};
  assign fetch_addr = line_base | (ADDR_WIDTH'(cnt) << WB_W);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = LOOKUP;
      LOOKUP:  if (we_q)        state_n = WRITE;
               else if (l3_hit) state_n = RESP;
               else             state_n = FETCH;
      FETCH:   state_n = WAIT;
      WAIT:    if (ram_r_valid) state_n = (cnt == LAST) ? FILL : FETCH;
      FILL:    state_n = RESP;
      WRITE:   state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      buffer      <= '0;
      resp_line_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      w_data_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q     <= req_we;
          addr_q   <= req_addr;
          w_data_q <= req_w_data;
        end
        LOOKUP: if (!we_q) begin
          if (l3_hit) resp_line_q <= l3_r_data;
          else        cnt         <= '0;
        end
        WAIT: if (ram_r_valid) begin
          buffer[cnt*DATA_WIDTH +: DATA_WIDTH] <= ram_r_data;
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        FILL:  resp_line_q <= buffer;
        WRITE: resp_line_q <= '0;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state register; address/data fields
  // come from the latched request and the fetch counter.
  assign req_ready       = (state == IDLE);
  assign resp_valid      = (state == RESP);
  assign resp_line       = resp_line_q;
  assign l3_valid        = (state == LOOKUP);
  assign l3_we           = (state == LOOKUP) && we_q;
  assign l3_addr         = addr_q;
  assign l3_w_data       = w_data_q;
  assign fill_en         = (state == FILL);
  assign fill_mark_valid = (state == FILL);
  assign fill_addr       = line_base;
  assign fill_data       = buffer;
  assign ram_re          = (state == FETCH);
  assign ram_we          = (state == WRITE);
  assign ram_addr        = (state == WRITE) ? word_addr : fetch_addr;
  assign ram_w_data      = w_data_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_l3_miss_handler.sv
// Bench for l3_miss_handler: behavioural L3 and RAM models around the DUT,
// directed plan steps followed by randomized reads/writes against a line model.
module tb_l3_miss_handler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0, req_we = 1'b0;
  logic [31:0]  req_addr = '0, req_w_data = '0;
  logic         req_ready, resp_valid;
  logic [127:0] resp_line;
  logic         l3_valid, l3_we;
  logic [31:0]  l3_addr, l3_w_data;
  logic [127:0] l3_r_data = '0;
  logic         l3_hit = 1'b0;
  logic         fill_en, fill_mark_valid;
  logic [31:0]  fill_addr;
  logic [127:0] fill_data;
  logic         ram_re, ram_we;
  logic [31:0]  ram_addr, ram_w_data;
  logic [31:0]  ram_r_data = '0;
  logic         ram_r_valid = 1'b0;
  logic [2:0]   dbg_state;

  l3_miss_handler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_w_data(req_w_data),
    .resp_valid(resp_valid), .resp_line(resp_line),
    .l3_valid(l3_valid), .l3_we(l3_we), .l3_addr(l3_addr), .l3_w_data(l3_w_data),
    .l3_r_data(l3_r_data), .l3_hit(l3_hit),
    .fill_en(fill_en), .fill_mark_valid(fill_mark_valid),
    .fill_addr(fill_addr), .fill_data(fill_data),
    .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_w_data(ram_w_data),
    .ram_r_data(ram_r_data), .ram_r_valid(ram_r_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // environment state
  int  lat = 1;
  bit  spur = 1'b0;
  logic [127:0] cache [logic [31:0]];
  logic [31:0]  ram_mem [logic [31:0]];

  // reference model
  logic [31:0]  ref_mem [logic [31:0]];
  bit           cached [logic [31:0]];

  // negedge monitor captures
  logic [31:0]  re_q[$];
  int           ram_we_cnt = 0, l3we_cnt = 0, fill_cnt = 0, resp_cnt = 0;
  logic [31:0]  we_addr_seen = '0, we_data_seen = '0, fill_addr_seen = '0;
  logic [127:0] fill_data_seen = '0;
  logic         n_l3we = 1'b0, n_fill = 1'b0, n_ramwe = 1'b0, n_ramre = 1'b0;
  logic [31:0]  n_l3addr = '0, n_l3data = '0, n_faddr = '0, n_waddr = '0, n_wdata = '0;
  logic [31:0]  n_raddr = '0;
  logic [127:0] n_fdata = '0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [127:0] ref_line(input logic [31:0] b);
    return {ref_word(b + 12), ref_word(b + 8), ref_word(b + 4), ref_word(b)};
  endfunction

  always @(negedge clk) begin
    n_l3we = l3_valid && l3_we;  n_l3addr = l3_addr; n_l3data = l3_w_data;
    n_fill = fill_en;            n_faddr = fill_addr; n_fdata = fill_data;
    n_ramwe = ram_we;            n_waddr = ram_addr;  n_wdata = ram_w_data;
    n_ramre = ram_re;            n_raddr = ram_addr;
    if (ram_re) re_q.push_back(ram_addr);
    if (ram_we) begin ram_we_cnt++; we_addr_seen = ram_addr; we_data_seen = ram_w_data; end
    if (l3_valid && l3_we) l3we_cnt++;
    if (fill_en && fill_mark_valid) begin
      fill_cnt++; fill_addr_seen = fill_addr; fill_data_seen = fill_data;
    end
    if (resp_valid) resp_cnt++;
  end

  // L3 and RAM behaviour: apply last cycle's writes at the edge, then drive
  // the combinational lookup result and any due RAM read response.
  int          cd = 0;
  bit          spur_now = 1'b0;
  logic [31:0] pend_addr = '0;
  always @(posedge clk) begin
    logic [31:0]  b;
    logic [127:0] tmp;
    bit           deliver;
    b = n_l3addr & ~32'hF;
    if (n_l3we && cache.exists(b)) begin
      tmp = cache[b];
      tmp[n_l3addr[3:2]*32 +: 32] = n_l3data;
      cache[b] = tmp;
    end
    if (n_fill) cache[n_faddr] = n_fdata;
    if (n_ramwe) ram_mem[n_waddr] = n_wdata;
    deliver = 1'b0;
    if (n_ramre) begin pend_addr = n_raddr; cd = lat; end
    if (cd > 0) begin
      if (cd == 1) deliver = 1'b1;
      cd--;
    end
    #1;
    b = l3_addr & ~32'hF;
    l3_hit = cache.exists(b);
    l3_r_data = cache.exists(b) ? cache[b] : '0;
    ram_r_valid = deliver || spur_now;
    if (deliver) ram_r_data = ram_mem.exists(pend_addr) ? ram_mem[pend_addr] : init_word(pend_addr);
    else         ram_r_data = 32'hBAD0BAD0;
    spur_now = deliver && spur;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    re_q.delete();
    ram_we_cnt = 0; l3we_cnt = 0; fill_cnt = 0; resp_cnt = 0;
  endtask

  // driver: one request, waits (bounded) for resp_valid and checks the outcome
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int l, input bit sp, input string tag);
    logic [31:0]  base;
    logic [127:0] exp_line;
    int           exp_lat, cyc;
    bit           hit, rdy_bad, miss;
    base = addr & ~32'hF;
    hit = cached.exists(base);
    miss = !we && !hit;
    lat = l; spur = sp;
    clear_mon();
    chk({tag, ".ready_idle"}, req_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_w_data = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_w_data = '0;
    cyc = 1; rdy_bad = 1'b0;
    while (resp_valid !== 1'b1 && cyc < 200) begin
      if (req_ready !== 1'b0) rdy_bad = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    if (we) begin
      ref_mem[addr & ~32'h3] = wd;
      exp_line = '0;
      exp_lat = 3;
    end else begin
      exp_line = ref_line(base);
      exp_lat = hit ? 2 : 2 + 4 * (1 + l) + 1;
      cached[base] = 1'b1;
    end
    chk({tag, ".resp_valid"}, resp_valid, 1'b1);
    chk({tag, ".latency"}, 128'(cyc), 128'(exp_lat));
    chk({tag, ".resp_line"}, resp_line, exp_line);
    chk({tag, ".ready_low"}, rdy_bad, 1'b0);
    chk({tag, ".ram_re_cnt"}, 128'(re_q.size()), miss ? 128'd4 : 128'd0);
    if (miss && re_q.size() == 4)
      for (int i = 0; i < 4; i++) chk({tag, ".ram_re_addr"}, re_q[i], base + 32'(i * 4));
    chk({tag, ".fill_cnt"}, 128'(fill_cnt), miss ? 128'd1 : 128'd0);
    if (miss) begin
      chk({tag, ".fill_addr"}, fill_addr_seen, base);
      chk({tag, ".fill_data"}, fill_data_seen, exp_line);
    end
    chk({tag, ".ram_we_cnt"}, 128'(ram_we_cnt), we ? 128'd1 : 128'd0);
    chk({tag, ".l3_we_cnt"}, 128'(l3we_cnt), we ? 128'd1 : 128'd0);
    if (we) begin
      chk({tag, ".ram_we_addr"}, we_addr_seen, addr & ~32'h3);
      chk({tag, ".ram_we_data"}, we_data_seen, wd);
    end
    @(posedge clk); #1;
    chk({tag, ".resp_one_cycle"}, resp_valid, 1'b0);
    chk({tag, ".resp_cnt"}, 128'(resp_cnt), 128'd1);
    chk({tag, ".ready_back"}, req_ready, 1'b1);
    chk({tag, ".resp_hold"}, resp_line, exp_line);
    spur = 1'b0;
  endtask

  initial begin
    bit rst_bad;
    ram_mem[32'h120] = 32'h11111111; ref_mem[32'h120] = 32'h11111111;
    ram_mem[32'h124] = 32'h22222222; ref_mem[32'h124] = 32'h22222222;
    ram_mem[32'h128] = 32'h33333333; ref_mem[32'h128] = 32'h33333333;
    ram_mem[32'h12C] = 32'h44444444; ref_mem[32'h12C] = 32'h44444444;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.resp_valid", resp_valid, 1'b0);
    chk("rst.resp_line", resp_line, '0);
    chk("rst.strobes", {l3_valid, l3_we, fill_en, fill_mark_valid, ram_re, ram_we}, '0);
    chk("rst.l3_addr", l3_addr, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_req(1'b0, 32'h120, '0, 1, 1'b0, "miss120");
    chk("miss120.line_value", resp_line, 128'h44444444_33333333_22222222_11111111);
    do_req(1'b0, 32'h12C, '0, 1, 1'b0, "hit12c");
    do_req(1'b1, 32'h124, 32'hDEADBEEF, 1, 1'b0, "wr124");
    do_req(1'b0, 32'h120, '0, 1, 1'b0, "rd_after_wr");
    chk("rd_after_wr.word1", resp_line[63:32], 32'hDEADBEEF);
    do_req(1'b1, 32'h4000, 32'hCAFEF00D, 1, 1'b0, "wr_uncached");
    do_req(1'b0, 32'h3000, '0, 3, 1'b1, "slow_miss");

    // reset in the second WAIT of a latency-3 miss; the late response lands in IDLE
    clear_mon();
    lat = 3; spur = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2000;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = '0;
    repeat (6) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rst_bad = 1'b0;
    repeat (6) begin
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || fill_en !== 1'b0) rst_bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort.idle_quiet", rst_bad, 1'b0);
    chk("abort.req_ready", req_ready, 1'b1);
    chk("abort.fill_cnt", 128'(fill_cnt), 128'd0);
    chk("abort.resp_cnt", 128'(resp_cnt), 128'd0);
    chk("abort.ram_re_cnt", 128'(re_q.size()), 128'd2);
    do_req(1'b0, 32'h2000, '0, 1, 1'b0, "after_abort");

    for (int n = 0; n < 24; n++) begin
      logic        we;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      a = 32'h1000 + 32'($urandom_range(0, 5)) * 16 + 32'($urandom_range(0, 3)) * 4;
      do_req(we, a, $urandom, int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
